// File: rtl/mul_wb_unit.sv
// Iterative unsigned shift-add multiplier that writes its 2W-bit product
// back to the register file as two bytes, low byte first.
module mul_wb_unit #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  opA,
    input  logic [W-1:0]  opB,
    input  logic [AW-1:0] dst_lo,
    input  logic [AW-1:0] dst_hi,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WR_LO,
        WR_HI
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplr;
    logic [AW-1:0]   lo_q;
    logic [AW-1:0]   hi_q;

    logic [W:0]      addend;
    logic [W:0]      sum;
    logic [2*W-1:0]  acc_nxt;
    logic            last;

    // The carry out of the upper-half add becomes the new msb after the shift.
    always_comb begin
        addend  = {1'b0, (mplr[0] ? mcand : {W{1'b0}})};
        sum     = {1'b0, acc[2*W-1:W]} + addend;
        acc_nxt = {sum, acc[W-1:1]};
        last    = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= opA;
                        mplr  <= opB;
                        lo_q  <= dst_lo;
                        hi_q  <= dst_hi;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    mplr <= mplr >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state   <= WR_LO;
                        wr_en   <= 1'b1;
                        wr_addr <= lo_q;
                        wr_data <= acc_nxt[W-1:0];
                    end
                end
                WR_LO: begin
                    state   <= WR_HI;
                    wr_addr <= hi_q;
                    wr_data <= acc[2*W-1:W];
                    done    <= 1'b1;
                end
                WR_HI: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_wb_unit.sv
// Directed and random checks of mul_wb_unit against a plain a*b model
// with a 4-entry register file written on negedge.
module tb_mul_wb_unit;

    localparam int W  = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [AW-1:0] dst_lo;
    logic [AW-1:0] dst_hi;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] rf [4];

    mul_wb_unit #(.W(W), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .opA     (opA),
        .opB     (opB),
        .dst_lo  (dst_lo),
        .dst_hi  (dst_hi),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) rf[wr_addr] = wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and check every cycle of its timeline.
    // A second start is pulsed at cycle 3 when inject is set.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input bit inject, input string tag);
        logic [2*W-1:0] prod;
        int nbusy;
        int ndone;
        prod  = 16'(a) * 16'(b);
        nbusy = 0;
        ndone = 0;
        @(negedge clk);
        opA    = a;
        opB    = b;
        dst_lo = lo;
        dst_hi = hi;
        start  = 1'b1;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                opA    = W'($urandom);
                opB    = W'($urandom);
                dst_lo = AW'($urandom);
                dst_hi = AW'($urandom);
            end
            if (inject && k == 3) begin
                opA   = 8'd2;
                opB   = 8'd2;
                start = 1'b1;
            end
            if (inject && k == 4) start = 1'b0;
            nbusy += int'(busy);
            ndone += int'(done);
            if (k == W + 1) begin
                chk({tag, "_lo_en"}, 32'(wr_en), 32'd1);
                chk({tag, "_lo_addr"}, 32'(wr_addr), 32'(lo));
                chk({tag, "_lo_data"}, 32'(wr_data), 32'(prod[W-1:0]));
            end else if (k == W + 2) begin
                chk({tag, "_hi_en"}, 32'(wr_en), 32'd1);
                chk({tag, "_hi_addr"}, 32'(wr_addr), 32'(hi));
                chk({tag, "_hi_data"}, 32'(wr_data), 32'(prod[2*W-1:W]));
                chk({tag, "_done"}, 32'(done), 32'd1);
            end else begin
                chk({tag, "_wr_idle"}, 32'(wr_en), 32'd0);
            end
            if (k == W + 3) chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        end
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W + 2));
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_rf_hi"}, 32'(rf[hi]), 32'(prod[2*W-1:W]));
        if (lo != hi) chk({tag, "_rf_lo"}, 32'(rf[lo]), 32'(prod[W-1:0]));
    endtask

    initial begin
        int nwr;
        reset  = 1'b1;
        start  = 1'b0;
        opA    = '0;
        opB    = '0;
        dst_lo = '0;
        dst_hi = '0;
        for (int i = 0; i < 4; i++) rf[i] = 8'hEE;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_mul(8'd13, 8'd11, 2'd1, 2'd2, 1'b0, "t1");
        chk("t1_r1", 32'(rf[1]), 32'h8F);
        chk("t1_r2", 32'(rf[2]), 32'h00);
        run_mul(8'hFF, 8'hFF, 2'd0, 2'd3, 1'b0, "t2");
        chk("t2_r0", 32'(rf[0]), 32'h01);
        chk("t2_r3", 32'(rf[3]), 32'hFE);
        run_mul(8'h00, 8'hA5, 2'd1, 2'd2, 1'b0, "t3");
        run_mul(8'd9, 8'd7, 2'd3, 2'd0, 1'b1, "t4");
        run_mul(8'h80, 8'h04, 2'd2, 2'd2, 1'b0, "t6");
        chk("t6_r2", 32'(rf[2]), 32'h02);

        // Reset during MUL aborts with no write afterwards.
        @(negedge clk);
        opA    = 8'h5A;
        opB    = 8'h3C;
        dst_lo = 2'd1;
        dst_hi = 2'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        chk("t5_wr_addr", 32'(wr_addr), 32'd0);
        chk("t5_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nwr = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            nwr += int'(wr_en) + int'(busy);
        end
        chk("t5_no_activity", 32'(nwr), 32'd0);
        run_mul(8'h5A, 8'h3C, 2'd1, 2'd3, 1'b0, "t5_after");

        for (int r = 0; r < 8; r++) begin
            run_mul(W'($urandom), W'($urandom), AW'($urandom),
                    AW'($urandom), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
